// File: rtl/cordic_sine_arbiter_if.sv
// Request, response and engine channels of the shared CORDIC sine arbiter.
// master = arbiter side, slave = requesters/consumer/engine side.
interface cordic_sine_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int BIT_WIDTH = 16
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_angle;
    logic [NUM_REQ-1:0]           req_ready;

    logic                         resp_valid;
    logic [ID_WIDTH-1:0]          resp_id;
    logic [BIT_WIDTH-1:0]         resp_value;
    logic                         resp_error;
    logic                         resp_ready;

    logic                         eng_start;
    logic [BIT_WIDTH-1:0]         eng_angle;
    logic                         eng_ready;
    logic                         eng_done;
    logic [BIT_WIDTH-1:0]         eng_value;

    modport master (
        input  req_valid, req_angle, resp_ready, eng_ready, eng_done, eng_value,
        output req_ready, resp_valid, resp_id, resp_value, resp_error, eng_start, eng_angle
    );

    modport slave (
        output req_valid, req_angle, resp_ready, eng_ready, eng_done, eng_value,
        input  req_ready, resp_valid, resp_id, resp_value, resp_error, eng_start, eng_angle
    );
endinterface

// File: rtl/cordic_sine_arbiter.sv
// Round-robin arbiter sharing one cordic_sine engine among NUM_REQ requesters.
// Optional watchdog: define CORDIC_ARB_TIMEOUT_EN to bound the engine wait to TIMEOUT cycles.
module cordic_sine_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int BIT_WIDTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    cordic_sine_arbiter_if.master bus
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_WIDTH != $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_bad_cfg
        $error("cordic_sine_arbiter: inconsistent NUM_REQ/ID_WIDTH/TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [ID_WIDTH-1:0] PTR_RST = ID_WIDTH'(NUM_REQ - 1);

    state_t               state_q, state_d;
    // ptr_q is both the round-robin pointer and the owner of the in-flight request
    logic [ID_WIDTH-1:0]  ptr_q;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic                 grant_vld;
    logic [BIT_WIDTH-1:0] angle_q;
    logic [BIT_WIDTH-1:0] value_q;
    logic [ID_WIDTH-1:0]  resp_id_q;
    logic                 done_q;
    logic                 done_rise;
    logic                 resp_ld;
    logic                 tmo_hit;

    // First valid requester searching upward from ptr+1; descending k so nearest wins
    always_comb begin : pick
        int                  s;
        logic [ID_WIDTH-1:0] si;
        grant_vld = 1'b0;
        grant_idx = '0;
        s         = 0;
        si        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            s = int'(ptr_q) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            si = ID_WIDTH'(s);
            if (bus.req_valid[si]) begin
                grant_vld = 1'b1;
                grant_idx = si;
            end
        end
    end

    assign done_rise = bus.eng_done & ~done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        resp_ld = 1'b0;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   if (bus.eng_ready) state_d = WAIT;
            WAIT: begin
                if (done_rise || tmo_hit) begin
                    state_d = RESP;
                    resp_ld = 1'b1;
                end
            end
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= PTR_RST;
            angle_q   <= '0;
            value_q   <= '0;
            resp_id_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= bus.eng_done;
            if (state_q == IDLE && grant_vld) begin
                ptr_q   <= grant_idx;
                angle_q <= bus.req_angle[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
            end
            if (resp_ld) begin
                resp_id_q <= ptr_q;
                value_q   <= done_rise ? bus.eng_value : '0;
            end
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Count is 0 in the first WAIT cycle, so the hit fires on the TIMEOUT-th WAIT cycle
    assign tmo_hit = (state_q == WAIT) && !done_rise && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ISSUE)     tmo_cnt <= '0;
            else if (state_q == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (resp_ld) err_q <= ~done_rise;
        end
    end

    assign bus.resp_error = err_q;
`else
    assign tmo_hit        = 1'b0;
    assign bus.resp_error = 1'b0;
`endif

    // req_ready is gated by reset so every output reads 0 while reset is held
    assign bus.req_ready  = (reset && state_q == IDLE && grant_vld) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_value = value_q;
    assign bus.eng_start  = (state_q == ISSUE);
    assign bus.eng_angle  = (state_q == ISSUE) ? angle_q : '0;

endmodule

// File: tb/tb_cordic_sine_arbiter.sv
// Scoreboard bench for cordic_sine_arbiter with a fixed-latency engine model.
module tb_cordic_sine_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int ID_WIDTH  = 2;
    localparam int BIT_WIDTH = 16;
    localparam int TIMEOUT   = 64;
    localparam int LAT       = 10;   // model: done rises LAT+1 cycles after the start cycle

    typedef struct {
        int                   id;
        logic [BIT_WIDTH-1:0] val;
        logic                 err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cordic_sine_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .BIT_WIDTH(BIT_WIDTH)) bus ();

    cordic_sine_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .BIT_WIDTH(BIT_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [BIT_WIDTH-1:0] eng_f(input logic [BIT_WIDTH-1:0] a);
        return (a == 16'h4000) ? 16'h7FFF : ((a ^ 16'hC35A) + 16'd1);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int first_one(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // engine model
    logic                 eng_rdy = 1'b1;
    logic                 stale_done = 1'b0;
    logic                 eng_dead = 1'b0;
    logic                 mdl_done, mbusy;
    logic [BIT_WIDTH-1:0] mdl_val, mang;
    int                   mcnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_done <= 1'b0;
            mbusy    <= 1'b0;
            mcnt     <= 0;
            mdl_val  <= '0;
            mang     <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (bus.eng_start && bus.eng_ready) begin
                mbusy <= 1'b1;
                mcnt  <= LAT;
                mang  <= bus.eng_angle;
            end else if (mbusy) begin
                if (mcnt == 1) begin
                    mbusy <= 1'b0;
                    if (!eng_dead) begin
                        mdl_done <= 1'b1;
                        mdl_val  <= eng_f(mang);
                    end
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    assign bus.eng_ready = eng_rdy & ~mbusy;
    assign bus.eng_done  = mdl_done | stale_done;
    assign bus.eng_value = mdl_val;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor / scoreboard state
    exp_t               sb[$];
    int                 grant_log[$];
    logic [NUM_REQ-1:0] acc_mask = '0;
    logic [NUM_REQ-1:0] refill = '0;
    logic               rr_mode = 1'b0;
    int                 exp_ptr = NUM_REQ - 1;
    int                 last_acc = -1;
    int                 hs_cnt = 0, resp_cnt = 0;
    int                 hs_cyc = -100, done_cyc = -100;

    initial begin : mon
        int   w, g;
        exp_t e;
        logic prev_md, prev_rv;
        prev_md = 1'b0;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                acc_mask = '0;
                prev_md  = 1'b0;
                prev_rv  = 1'b0;
            end else begin
                acc_mask = bus.req_valid & bus.req_ready;
                if (bus.req_ready != '0) begin
                    w = rr_pick(bus.req_valid, exp_ptr);
                    g = first_one(bus.req_ready);
                    chk("rdy_onehot", 32'($countones(bus.req_ready)), 32'd1);
                    chk("grant", 32'(g), 32'(w));
                    grant_log.push_back(g);
                    if (rr_mode && last_acc >= 0) chk("spacing", 32'(cyc - last_acc), 32'(LAT + 4));
                    last_acc = cyc;
                    if (w >= 0) begin
                        exp_ptr = w;
                        e.id  = w;
                        e.err = eng_dead;
                        e.val = eng_dead ? '0 : eng_f(bus.req_angle[w*BIT_WIDTH +: BIT_WIDTH]);
                        sb.push_back(e);
                    end
                end
                if (bus.eng_start && bus.eng_ready) begin
                    hs_cnt++;
                    hs_cyc = cyc;
                end
                if (mdl_done && !prev_md) done_cyc = cyc;
                if (bus.resp_valid && !prev_rv) begin
                    if (eng_dead) begin
`ifdef CORDIC_ARB_TIMEOUT_EN
                        chk("tmo_lat", 32'(cyc), 32'(hs_cyc + 1 + TIMEOUT));
`endif
                    end else begin
                        chk("resp_lat", 32'(cyc), 32'(done_cyc + 1));
                    end
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    resp_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                        chk("resp_value", 32'(bus.resp_value), 32'(e.val));
                        chk("resp_error", 32'(bus.resp_error), 32'(e.err));
                    end
                end
                prev_md = mdl_done;
                prev_rv = bus.resp_valid;
            end
        end
    end

    // one cycle; accepted requesters either present a fresh angle or drop valid
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_mask[i]) begin
                if (refill[i]) bus.req_angle[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($urandom);
                else           bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_resps(input int target, input int budget);
        int t = 0;
        while (resp_cnt < target && t < budget) begin
            tick();
            t++;
        end
        chk("resp_wait", 32'(resp_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = '0;
        refill        = '0;
        rr_mode       = 1'b0;
        eng_rdy       = 1'b1;
        stale_done    = 1'b0;
        #10;
        sb.delete();
        grant_log.delete();
        exp_ptr  = NUM_REQ - 1;
        last_acc = -1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic chk_outs_zero(input string p);
        chk({p, "_req_ready"},  32'(bus.req_ready),  32'd0);
        chk({p, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({p, "_resp_id"},    32'(bus.resp_id),    32'd0);
        chk({p, "_resp_value"}, 32'(bus.resp_value), 32'd0);
        chk({p, "_resp_error"}, 32'(bus.resp_error), 32'd0);
        chk({p, "_eng_start"},  32'(bus.eng_start),  32'd0);
        chk({p, "_eng_angle"},  32'(bus.eng_angle),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, seen, t;
        bus.req_valid  = '1;
        bus.req_angle  = '0;
        bus.resp_ready = 1'b0;

        // reset state, with requests pending so req_ready gating is exercised
        #12;
        chk_outs_zero("rst");
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // single request
        bus.resp_ready = 1'b1;
        bus.req_angle[0 +: BIT_WIDTH] = 16'h4000;
        bus.req_valid = 4'b0001;
        base = resp_cnt;
        @(negedge clk);
        chk("c0_req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("c1_eng_start", 32'(bus.eng_start), 32'd1);
        chk("c1_eng_angle", 32'(bus.eng_angle), 32'h4000);
        tick();
        @(negedge clk);
        chk("c2_eng_start", 32'(bus.eng_start), 32'd0);
        wait_resps(base + 1, 100);

        // round robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) bus.req_angle[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($urandom);
        refill        = '1;
        rr_mode       = 1'b1;
        bus.req_valid = '1;
        base = resp_cnt;
        wait_resps(base + 6, 200);
        chk("rr_count", 32'(grant_log.size() >= 6), 32'd1);
        if (grant_log.size() >= 6)
            for (int k = 0; k < 6; k++) chk("rr_order", 32'(grant_log[k]), 32'(k % NUM_REQ));

        // response backpressure
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req_angle[2*BIT_WIDTH +: BIT_WIDTH] = 16'h1234;
        bus.req_valid = 4'b0100;
        base = resp_cnt;
        t = 0;
        while (!bus.resp_valid && t < 100) begin
            tick();
            t++;
        end
        chk("bp_resp_seen", 32'(bus.resp_valid), 32'd1);
        bus.req_angle[3*BIT_WIDTH +: BIT_WIDTH] = 16'h0BCD;
        bus.req_valid[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_id",    32'(bus.resp_id),    32'd2);
            chk("bp_value", 32'(bus.resp_value), 32'(eng_f(16'h1234)));
            chk("bp_ready", 32'(bus.req_ready),  32'd0);
            tick();
        end
        chk("bp_none_yet", 32'(resp_cnt - base), 32'd0);
        bus.resp_ready = 1'b1;
        wait_resps(base + 1, 10);
        wait_resps(base + 2, 100);

        // engine busy for 7 ISSUE cycles, stale done high on WAIT entry
        do_reset();
        eng_rdy = 1'b0;
        bus.req_angle[1*BIT_WIDTH +: BIT_WIDTH] = 16'h2468;
        bus.req_valid = 4'b0010;
        base = resp_cnt;
        seen = hs_cnt;
        tick();
        stale_done = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("busy_start", 32'(bus.eng_start), 32'd1);
            chk("busy_angle", 32'(bus.eng_angle), 32'h2468);
            tick();
        end
        eng_rdy = 1'b1;
        tick();
        tick();
        tick();
        stale_done = 1'b0;
        wait_resps(base + 1, 100);
        chk("busy_hs_once", 32'(hs_cnt - seen), 32'd1);

        // reset during WAIT abandons the transaction
        do_reset();
        bus.req_angle[0 +: BIT_WIDTH] = 16'h1111;
        bus.req_valid = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        bus.req_angle[1*BIT_WIDTH +: BIT_WIDTH] = 16'h5555;
        bus.req_angle[3*BIT_WIDTH +: BIT_WIDTH] = 16'h7777;
        bus.req_valid = 4'b1010;
        #2;
        reset = 1'b0;
        #1;
        chk_outs_zero("midrst");
        #5;
        sb.delete();
        grant_log.delete();
        exp_ptr  = NUM_REQ - 1;
        last_acc = -1;
        base = resp_cnt;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_resps(base + 2, 100);
        chk("midrst_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("midrst_first", 32'(grant_log[0]), 32'd1);
            chk("midrst_second", 32'(grant_log[1]), 32'd3);
        end

        // engine never completes
        do_reset();
        eng_dead = 1'b1;
        bus.req_valid = 4'b0001;
        base = resp_cnt;
`ifdef CORDIC_ARB_TIMEOUT_EN
        wait_resps(base + 1, TIMEOUT + 20);
`else
        seen = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus.resp_valid) seen++;
        end
        chk("no_tmo_resp", 32'(seen), 32'd0);
`endif
        eng_dead = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
